// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register target: FSM states, bit indices, R/W values.
package i2c_pkg;
   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   localparam logic [3:0] LAST_DATA_BIT = 4'd7;
   localparam logic [3:0] ACK_BIT       = 4'd8;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers, edge detection and START/STOP detection.
// Events are valid SYNC_STAGES clk after a pin edge and consumed on the next clk.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);
   logic [SYNC_STAGES-1:0] scl_q;
   logic [SYNC_STAGES-1:0] sda_q;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // Flops reset to 1 so an idle (pulled-up) bus produces no edges out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scl_q <= '1;
         sda_q <= '1;
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_q <= {scl_q[SYNC_STAGES-2:0], scl_in};
         sda_q <= {sda_q[SYNC_STAGES-2:0], sda_in};
         scl_d <= scl_s;
         sda_d <= sda_s;
      end
   end

   assign scl_s     = scl_q[SYNC_STAGES-1];
   assign sda_s     = sda_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_target_regs.sv
// Oversampled I2C target with pointer-addressed register port and optional auto-increment.
// sda_oe moves one clk after a detected scl_fall; reg_rdata is taken one clk after reg_re.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter int REG_AW      = 8,
   parameter int NUM_REGS    = 256,
   parameter int AUTO_INC    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   input  logic [6:0]        slv_addr,
   output logic [REG_AW-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              busy
);
   localparam logic [REG_AW:0]   REG_LIMIT = NUM_REGS[REG_AW:0];
   localparam logic [REG_AW-1:0] LAST_REG  = REG_LIMIT[REG_AW-1:0] - 1'b1;
   localparam logic              INC_EN    = (AUTO_INC != 0);

   logic       scl_rise, scl_fall, sda_s, start_det, stop_det;
   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] rx_byte;
   logic       rw;
   logic       ack_phase;   // set once the ACK bit's SCL high has been seen
   logic       re_next;
   logic       load_rd;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rstn(rstn), .scl_in(scl_in), .sda_in(sda_in),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_s(sda_s),
      .start_det(start_det), .stop_det(stop_det)
   );

   assign rx_byte = {shreg[6:0], sda_s};

   function automatic logic [REG_AW-1:0] ptr_inc(input logic [REG_AW-1:0] p);
      return (p == LAST_REG) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         rw        <= RW_WRITE;
         ack_phase <= 1'b0;
         re_next   <= 1'b0;
         load_rd   <= 1'b0;
         sda_oe    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_we  <= 1'b0;
         reg_re  <= re_next;
         re_next <= 1'b0;
         load_rd <= reg_re;
         if (load_rd) shreg <= reg_rdata;
         if (reg_we && INC_EN) reg_addr <= ptr_inc(reg_addr);

         if (start_det) begin
            state   <= DEV_ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
         end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               DEV_ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_DATA_BIT) begin
                        bit_cnt   <= ACK_BIT;
                        ack_phase <= 1'b0;
                        if (state == DEV_ADDR) begin
                           if (rx_byte[7:1] == slv_addr) begin
                              state <= DEV_ACK;
                              rw    <= rx_byte[0];
                              busy  <= 1'b1;
                           end else begin
                              state <= WAIT_STOP;
                           end
                        end else if (state == PTR) begin
                           if ({1'b0, rx_byte[REG_AW-1:0]} < REG_LIMIT) begin
                              state    <= PTR_ACK;
                              reg_addr <= rx_byte[REG_AW-1:0];
                           end else begin
                              state <= WAIT_STOP;
                           end
                        end else begin
                           state     <= WDATA_ACK;
                           reg_we    <= 1'b1;
                           reg_wdata <= rx_byte;
                        end
                     end
                  end
               end
               // First fall opens the ACK bit, the rise samples it, the second fall closes it.
               DEV_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK: begin
                  if (scl_fall && !ack_phase) begin
                     sda_oe <= (state != RDATA_ACK);
                  end else if (scl_rise) begin
                     ack_phase <= 1'b1;
                     if (state == DEV_ACK && rw == RW_READ) reg_re <= 1'b1;
                     if (state == RDATA_ACK) begin
                        if (sda_s) begin
                           state <= WAIT_STOP;
                        end else begin
                           re_next <= 1'b1;
                           if (INC_EN) reg_addr <= ptr_inc(reg_addr);
                        end
                     end
                  end else if (scl_fall) begin
                     bit_cnt   <= '0;
                     ack_phase <= 1'b0;
                     sda_oe    <= 1'b0;
                     case (state)
                        DEV_ACK: begin
                           if (rw == RW_WRITE) begin
                              state <= PTR;
                           end else begin
                              state  <= RDATA;
                              sda_oe <= ~shreg[7];
                           end
                        end
                        RDATA_ACK: begin
                           state  <= RDATA;
                           sda_oe <= ~shreg[7];
                        end
                        default: state <= WDATA;
                     endcase
                  end
               end
               RDATA: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], 1'b0};
                     if (bit_cnt == LAST_DATA_BIT) begin
                        bit_cnt   <= ACK_BIT;
                        ack_phase <= 1'b0;
                        state     <= RDATA_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else if (scl_fall) begin
                     sda_oe <= ~shreg[7];
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master against i2c_target_regs with a transaction-level register model.
module tb_i2c_target_regs;
   localparam int NUM_REGS = 16;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       m_scl, m_sda, sda_line;
   logic       sda_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, reg_re, busy;
   logic       may_drive;

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_ptr;
   ev_t  exp_q[$];

   assign sda_line = m_sda & ~sda_oe;

   i2c_target_regs #(.REG_AW(8), .NUM_REGS(NUM_REGS), .AUTO_INC(1), .SYNC_STAGES(2)) dut (
      .clk(clk), .rstn(rstn), .scl_in(m_scl), .sda_in(sda_line), .sda_oe(sda_oe),
      .slv_addr(7'h42), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [7:0] rd_model(input logic [7:0] a);
      return {a[3:0], ~a[3:0]};
   endfunction

   // Register-file stub: read data one clk after the request.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) reg_rdata <= 8'h00;
      else if (reg_re) reg_rdata <= rd_model(reg_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic q(input int n);
      repeat (4 * n) @(negedge clk);
   endtask

   // ---------------- model ----------------
   task automatic set_ptr(input int p);
      if (p < NUM_REGS) m_ptr = p;
   endtask

   task automatic m_write(input logic [7:0] d);
      ev_t e;
      e.we = 1'b1; e.addr = 8'(m_ptr); e.data = d;
      exp_q.push_back(e);
      m_ptr = (m_ptr + 1) % NUM_REGS;
   endtask

   task automatic m_read_req();
      ev_t e;
      e.we = 1'b0; e.addr = 8'(m_ptr); e.data = 8'h00;
      exp_q.push_back(e);
   endtask

   task automatic m_read_byte(input logic ack, output logic [7:0] exp);
      exp = rd_model(8'(m_ptr));
      if (ack) begin
         m_ptr = (m_ptr + 1) % NUM_REGS;
         m_read_req();
      end
   endtask

   // ---------------- bus master ----------------
   task automatic send_bit(input logic b, output logic r);
      m_sda = b; q(1);
      m_scl = 1'b1; q(1);
      r = sda_line; q(1);
      m_scl = 1'b0; q(1);
   endtask

   task automatic bus_start();
      if (!m_scl) begin
         m_sda = 1'b1; q(1);
         m_scl = 1'b1; q(1);
      end
      m_sda = 1'b0; q(1);
      m_scl = 1'b0; q(1);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; q(1);
      m_scl = 1'b1; q(1);
      m_sda = 1'b1; q(2);
   endtask

   task automatic wr(input logic [7:0] b, input logic exp_ack, input string name);
      logic r;
      for (int i = 7; i >= 0; i--) send_bit(b[i], r);
      send_bit(1'b1, r);
      check(name, !r, exp_ack);
   endtask

   task automatic rd(input logic ack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, r);
         b[i] = r;
      end
      send_bit(!ack, r);
   endtask

   // ---------------- per-cycle compare ----------------
   task automatic monitor();
      ev_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (!may_drive) check("sda_released", sda_oe, 0);
            if (reg_we || reg_re) begin
               check("strobe_exclusive", reg_we & reg_re, 0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_strobe: we=%0d re=%0d addr=%0h, none expected",
                           reg_we, reg_re, reg_addr);
               end else begin
                  e = exp_q.pop_front();
                  check("strobe_kind", reg_we, e.we);
                  check("strobe_addr", reg_addr, e.addr);
                  if (e.we) check("strobe_wdata", reg_wdata, e.data);
               end
            end
         end
      end
   endtask

   task automatic run_all();
      logic [7:0] got, expb;
      logic       r;

      repeat (3) @(negedge clk);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_reg_wdata", reg_wdata, 0);
      check("rst_reg_we", reg_we, 0);
      check("rst_reg_re", reg_re, 0);
      check("rst_busy", busy, 0);
      rstn = 1'b1;
      q(2);

      // Write with auto-increment
      bus_start();
      wr(8'h84, 1'b1, "s1_dev_ack");
      set_ptr(8'h03);
      wr(8'h03, 1'b1, "s1_ptr_ack");
      m_write(8'hAA);
      wr(8'hAA, 1'b1, "s1_d0_ack");
      m_write(8'h55);
      wr(8'h55, 1'b1, "s1_d1_ack");
      check("s1_busy", busy, 1);
      bus_stop();
      check("s1_busy_after_stop", busy, 0);
      check("s1_ptr_model", reg_addr, m_ptr);
      check("s1_ptr_literal", reg_addr, 5);
      check("s1_events_done", exp_q.size(), 0);

      // Write pointer, repeated START, read two bytes with wrap
      bus_start();
      wr(8'h84, 1'b1, "s2_dev_ack");
      set_ptr(8'h0F);
      wr(8'h0F, 1'b1, "s2_ptr_ack");
      bus_start();
      m_read_req();
      wr(8'h85, 1'b1, "s2_rd_ack");
      check("s2_busy", busy, 1);
      m_read_byte(1'b1, expb);
      rd(1'b1, got);
      check("s2_byte1_model", got, expb);
      check("s2_byte1_literal", got, 8'hF0);
      m_read_byte(1'b0, expb);
      rd(1'b0, got);
      check("s2_byte2_model", got, expb);
      check("s2_byte2_literal", got, 8'h0F);
      bus_stop();
      check("s2_ptr_wrap", reg_addr, 0);
      check("s2_events_done", exp_q.size(), 0);

      // Address mismatch: target never drives
      may_drive = 1'b0;
      bus_start();
      wr(8'h86, 1'b0, "s3_no_ack");
      check("s3_busy", busy, 0);
      wr(8'h12, 1'b0, "s3_ignored");
      bus_stop();
      may_drive = 1'b1;

      // Pointer out of range
      bus_start();
      wr(8'h84, 1'b1, "s4a_dev_ack");
      set_ptr(8'h09);
      wr(8'h09, 1'b1, "s4a_ptr_ack");
      bus_stop();
      bus_start();
      wr(8'h84, 1'b1, "s4_dev_ack");
      may_drive = 1'b0;
      set_ptr(8'h20);
      wr(8'h20, 1'b0, "s4_ptr_nack");
      wr(8'h11, 1'b0, "s4_data_ignored");
      bus_stop();
      may_drive = 1'b1;
      check("s4_ptr_model", reg_addr, m_ptr);
      check("s4_ptr_literal", reg_addr, 9);

      // STOP after 4 bits of a data byte
      bus_start();
      wr(8'h84, 1'b1, "s5_dev_ack");
      set_ptr(8'h02);
      wr(8'h02, 1'b1, "s5_ptr_ack");
      send_bit(1'b1, r); send_bit(1'b0, r); send_bit(1'b1, r); send_bit(1'b0, r);
      bus_stop();
      check("s5_sda_oe", sda_oe, 0);
      check("s5_busy", busy, 0);
      check("s5_ptr", reg_addr, 2);
      check("s5_events_done", exp_q.size(), 0);

      // Reset during the address ACK low phase
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(got[i] & 1'b0 | (8'h84 >> i) & 8'h01, r);
      check("s6_ack_driven", sda_oe, 1);
      rstn = 1'b0;
      #1;
      check("s6_async_release", sda_oe, 0);
      m_ptr = 0;
      exp_q.delete();
      check("s6_rst_reg_addr", reg_addr, 0);
      check("s6_rst_reg_wdata", reg_wdata, 0);
      check("s6_rst_busy", busy, 0);
      check("s6_rst_we_re", {reg_we, reg_re}, 0);
      q(1);
      rstn = 1'b1;
      q(1);
      send_bit(1'b1, r);
      bus_stop();
      check("s6_idle_busy", busy, 0);
      bus_start();
      wr(8'h84, 1'b1, "s6_dev_ack");
      set_ptr(8'h07);
      wr(8'h07, 1'b1, "s6_ptr_ack");
      m_write(8'h3C);
      wr(8'h3C, 1'b1, "s6_d0_ack");
      bus_stop();
      check("s6_ptr_model", reg_addr, m_ptr);
      check("s6_ptr_literal", reg_addr, 8);
      check("s6_events_done", exp_q.size(), 0);
   endtask

   initial begin
      rstn      = 1'b0;
      m_scl     = 1'b1;
      m_sda     = 1'b1;
      may_drive = 1'b1;
      m_ptr     = 0;
      fork
         run_all();
         monitor();
      join_any
      disable fork;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
